// File: rtl/track_query_arbiter.sv
// Shares the track/obstacle tile RAMs between the renderer and two physics requesters.
// Lookups are issued round-robin during blanking and returned after a fixed RAM latency.
module track_query_arbiter #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int RAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        p_req_in,
  input  logic [10:0] p_x_in,
  input  logic [10:0] p_y_in,
  output logic        p_ready_out,
  output logic        p_valid_out,
  output logic [3:0]  p_tile_out,
  output logic [3:0]  p_obstacle_out,
  input  logic        o_req_in,
  input  logic [10:0] o_x_in,
  input  logic [10:0] o_y_in,
  output logic        o_ready_out,
  output logic        o_valid_out,
  output logic [3:0]  o_tile_out,
  output logic [3:0]  o_obstacle_out,
  output logic        map_sel_out,
  output logic [7:0]  map_addr_out,
  input  logic [3:0]  track_data_in,
  input  logic [3:0]  obstacle_data_in
);

  localparam int DEPTH = RAM_LATENCY + 1;

  logic             blank_s;
  logic             p_elig_s;
  logic             o_elig_s;
  logic             p_grant_s;
  logic             o_grant_s;
  logic             accept_s;

  logic             rr_q, rr_d;
  logic             p_out_q, p_out_d;
  logic             o_out_q, o_out_d;
  logic [DEPTH-1:0] pipe_v_q, pipe_v_d;
  logic [DEPTH-1:0] pipe_id_q, pipe_id_d;
  logic             p_valid_q, p_valid_d;
  logic             o_valid_q, o_valid_d;
  logic [3:0]       p_tile_q, p_tile_d;
  logic [3:0]       p_obst_q, p_obst_d;
  logic [3:0]       o_tile_q, o_tile_d;
  logic [3:0]       o_obst_q, o_obst_d;

  // Grant: rr_q = 0 favours the player on contention; reset suppresses grants.
  always_comb begin
    blank_s   = (hcount_in >= 11'(H_ACTIVE)) || (vcount_in >= 10'(V_ACTIVE));
    p_elig_s  = p_req_in && !p_out_q && blank_s && !rst_in;
    o_elig_s  = o_req_in && !o_out_q && blank_s && !rst_in;
    p_grant_s = 1'b0;
    o_grant_s = 1'b0;
    if (p_elig_s && o_elig_s) begin
      if (rr_q == 1'b0) begin
        p_grant_s = 1'b1;
      end else begin
        o_grant_s = 1'b1;
      end
    end else if (p_elig_s) begin
      p_grant_s = 1'b1;
    end else if (o_elig_s) begin
      o_grant_s = 1'b1;
    end else begin
      p_grant_s = 1'b0;
    end
    accept_s = p_grant_s || o_grant_s;
  end

  // Same-cycle address issue for the granted requester.
  always_comb begin
    p_ready_out  = p_grant_s;
    o_ready_out  = o_grant_s;
    map_sel_out  = accept_s;
    map_addr_out = 8'h00;
    if (p_grant_s) begin
      map_addr_out = {p_y_in[10:7], p_x_in[10:7]};
    end else if (o_grant_s) begin
      map_addr_out = {o_y_in[10:7], o_x_in[10:7]};
    end else begin
      map_addr_out = 8'h00;
    end
  end

  // Next state: pointer, outstanding flags, latency pipeline and result capture.
  always_comb begin
    rr_d      = rr_q;
    p_out_d   = p_out_q;
    o_out_d   = o_out_q;
    pipe_v_d  = {pipe_v_q[DEPTH-2:0], accept_s};
    pipe_id_d = {pipe_id_q[DEPTH-2:0], o_grant_s};
    if (p_grant_s) begin
      rr_d = 1'b1;
    end else if (o_grant_s) begin
      rr_d = 1'b0;
    end else begin
      rr_d = rr_q;
    end
    // The last pipeline stage coincides with the valid pulse, freeing the requester.
    if (p_grant_s) begin
      p_out_d = 1'b1;
    end else if (pipe_v_q[DEPTH-1] && !pipe_id_q[DEPTH-1]) begin
      p_out_d = 1'b0;
    end else begin
      p_out_d = p_out_q;
    end
    if (o_grant_s) begin
      o_out_d = 1'b1;
    end else if (pipe_v_q[DEPTH-1] && pipe_id_q[DEPTH-1]) begin
      o_out_d = 1'b0;
    end else begin
      o_out_d = o_out_q;
    end
    p_valid_d = pipe_v_q[DEPTH-2] && !pipe_id_q[DEPTH-2];
    o_valid_d = pipe_v_q[DEPTH-2] && pipe_id_q[DEPTH-2];
    if (p_valid_d) begin
      p_tile_d = track_data_in;
      p_obst_d = obstacle_data_in;
    end else begin
      p_tile_d = p_tile_q;
      p_obst_d = p_obst_q;
    end
    if (o_valid_d) begin
      o_tile_d = track_data_in;
      o_obst_d = obstacle_data_in;
    end else begin
      o_tile_d = o_tile_q;
      o_obst_d = o_obst_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_q      <= 1'b0;
      p_out_q   <= 1'b0;
      o_out_q   <= 1'b0;
      pipe_v_q  <= '0;
      pipe_id_q <= '0;
      p_valid_q <= 1'b0;
      o_valid_q <= 1'b0;
      p_tile_q  <= 4'h0;
      p_obst_q  <= 4'h0;
      o_tile_q  <= 4'h0;
      o_obst_q  <= 4'h0;
    end else begin
      rr_q      <= rr_d;
      p_out_q   <= p_out_d;
      o_out_q   <= o_out_d;
      pipe_v_q  <= pipe_v_d;
      pipe_id_q <= pipe_id_d;
      p_valid_q <= p_valid_d;
      o_valid_q <= o_valid_d;
      p_tile_q  <= p_tile_d;
      p_obst_q  <= p_obst_d;
      o_tile_q  <= o_tile_d;
      o_obst_q  <= o_obst_d;
    end
  end

  assign p_valid_out    = p_valid_q;
  assign o_valid_out    = o_valid_q;
  assign p_tile_out     = p_tile_q;
  assign p_obstacle_out = p_obst_q;
  assign o_tile_out     = o_tile_q;
  assign o_obstacle_out = o_obst_q;

endmodule

// File: tb/tb_track_query_arbiter.sv
// Bench for track_query_arbiter: directed stimulus, a per-cycle reference model
// of the arbitration rules, and a few literal expectations.
module tb_track_query_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic        p_req_in = 1'b0, o_req_in = 1'b0;
  logic [10:0] p_x_in = 11'd0, p_y_in = 11'd0, o_x_in = 11'd0, o_y_in = 11'd0;
  logic        p_ready_out, p_valid_out, o_ready_out, o_valid_out, map_sel_out;
  logic [3:0]  p_tile_out, p_obstacle_out, o_tile_out, o_obstacle_out;
  logic [7:0]  map_addr_out;
  logic [3:0]  track_data_in, obstacle_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  track_query_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .p_req_in(p_req_in), .p_x_in(p_x_in), .p_y_in(p_y_in), .p_ready_out(p_ready_out),
    .p_valid_out(p_valid_out), .p_tile_out(p_tile_out), .p_obstacle_out(p_obstacle_out),
    .o_req_in(o_req_in), .o_x_in(o_x_in), .o_y_in(o_y_in), .o_ready_out(o_ready_out),
    .o_valid_out(o_valid_out), .o_tile_out(o_tile_out), .o_obstacle_out(o_obstacle_out),
    .map_sel_out(map_sel_out), .map_addr_out(map_addr_out),
    .track_data_in(track_data_in), .obstacle_data_in(obstacle_data_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] ram_track(input logic [7:0] a);
    return a[7:4] - a[3:0];
  endfunction
  function automatic logic [3:0] ram_obst(input logic [7:0] a);
    return a[7:4] ^ a[3:0];
  endfunction
  function automatic logic [7:0] tile_addr(input logic [10:0] x, input logic [10:0] y);
    return {y[10:7], x[10:7]};
  endfunction

  // Two-cycle RAM; the renderer's own address (hcount) is seen when the arbiter does not own the bus.
  logic [7:0] ram_a1 = 8'h00, ram_a2 = 8'h00;
  always @(posedge clk_in) begin
    ram_a1 <= map_sel_out ? map_addr_out : hcount_in[7:0];
    ram_a2 <= ram_a1;
  end
  assign track_data_in    = ram_track(ram_a2);
  assign obstacle_data_in = ram_obst(ram_a2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: per-requester outstanding flag, due cycle and expected result.
  int         cyc = 0;
  bit         m_out [2];
  int         m_due [2] = '{-1, -1};
  logic [3:0] m_tile [2], m_obst [2];
  logic [3:0] m_htile [2] = '{4'h0, 4'h0};
  logic [3:0] m_hobst [2] = '{4'h0, 4'h0};
  int         m_ptr = 0;

  always @(negedge clk_in) begin
    bit         blank;
    bit         elig [2];
    bit         expv [2];
    int         g;
    logic [7:0] ea;
    cyc++;
    if (rst_in) begin
      check("rst p_ready", p_ready_out, 0);
      check("rst o_ready", o_ready_out, 0);
      check("rst map_sel", map_sel_out, 0);
      check("rst map_addr", map_addr_out, 0);
      check("rst p_valid", p_valid_out, 0);
      check("rst o_valid", o_valid_out, 0);
      check("rst p_tile", p_tile_out, 0);
      check("rst p_obst", p_obstacle_out, 0);
      check("rst o_tile", o_tile_out, 0);
      check("rst o_obst", o_obstacle_out, 0);
      m_out = '{0, 0};
      m_due = '{-1, -1};
      m_htile = '{4'h0, 4'h0};
      m_hobst = '{4'h0, 4'h0};
      m_ptr = 0;
    end else begin
      blank   = (hcount_in >= 11'd1280) || (vcount_in >= 10'd720);
      elig[0] = p_req_in && !m_out[0] && blank;
      elig[1] = o_req_in && !m_out[1] && blank;
      g = -1;
      if (elig[0] && elig[1]) g = m_ptr;
      else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
      ea = 8'h00;
      if (g == 0) ea = tile_addr(p_x_in, p_y_in);
      if (g == 1) ea = tile_addr(o_x_in, o_y_in);
      for (int i = 0; i < 2; i++) begin
        expv[i] = (m_due[i] == cyc);
        if (expv[i]) begin
          m_htile[i] = m_tile[i];
          m_hobst[i] = m_obst[i];
        end
      end
      check("p_ready", p_ready_out, (g == 0));
      check("o_ready", o_ready_out, (g == 1));
      check("map_sel", map_sel_out, (g >= 0));
      check("map_addr", map_addr_out, ea);
      check("p_valid", p_valid_out, expv[0]);
      check("o_valid", o_valid_out, expv[1]);
      check("p_tile", p_tile_out, m_htile[0]);
      check("p_obst", p_obstacle_out, m_hobst[0]);
      check("o_tile", o_tile_out, m_htile[1]);
      check("o_obst", o_obstacle_out, m_hobst[1]);
      for (int i = 0; i < 2; i++) begin
        if (expv[i]) begin
          m_out[i] = 0;
          m_due[i] = -1;
        end
      end
      if (g >= 0) begin
        m_out[g]  = 1;
        m_due[g]  = cyc + 3;
        m_tile[g] = ram_track(ea);
        m_obst[g] = ram_obst(ea);
        m_ptr     = 1 - g;
      end
    end
  end

  int cnt;
  int first_at;

  initial begin
    #2 rst_in = 1'b1;
    repeat (3) step();
    rst_in = 1'b0;
    step();

    // Single lookup: address 0x53 -> track 2, obstacle 6 three cycles later.
    hcount_in = 11'd1300; vcount_in = 10'd100;
    p_x_in = 11'h1A0; p_y_in = 11'h280; p_req_in = 1'b1;
    #1;
    check("lit single p_ready", p_ready_out, 1);
    check("lit single map_sel", map_sel_out, 1);
    check("lit single map_addr", map_addr_out, 8'h53);
    step(); p_req_in = 1'b0;
    step(); step();
    check("lit single p_valid", p_valid_out, 1);
    check("lit single p_tile", p_tile_out, 4'd2);
    check("lit single p_obst", p_obstacle_out, 4'd6);
    step();
    check("lit hold p_valid", p_valid_out, 0);
    check("lit hold p_tile", p_tile_out, 4'd2);

    // Asynchronous reset while a request would otherwise be granted.
    rst_in = 1'b1; p_req_in = 1'b1;
    #1;
    check("lit async p_ready", p_ready_out, 0);
    check("lit async map_sel", map_sel_out, 0);
    check("lit async p_tile", p_tile_out, 0);
    step(); rst_in = 1'b0; p_req_in = 1'b0;
    step();

    // Round-robin: pointer at player after reset.
    o_x_in = 11'h100; o_y_in = 11'h380;
    p_req_in = 1'b1; o_req_in = 1'b1;
    #1;
    check("lit rr1 p_ready", p_ready_out, 1);
    check("lit rr1 o_ready", o_ready_out, 0);
    step();
    check("lit rr1 o_ready next", o_ready_out, 1);
    check("lit rr1 o_addr", map_addr_out, 8'h72);
    step(); p_req_in = 1'b0; o_req_in = 1'b0;
    step();
    check("lit rr1 p_valid", p_valid_out, 1);
    check("lit rr1 o_valid early", o_valid_out, 0);
    step();
    check("lit rr1 o_valid", o_valid_out, 1);
    check("lit rr1 o_tile", o_tile_out, 4'd5);
    check("lit rr1 o_obst", o_obstacle_out, 4'd5);
    step();
    // A lone player lookup leaves the pointer at the opponent.
    p_req_in = 1'b1; step(); p_req_in = 1'b0;
    repeat (4) step();
    p_req_in = 1'b1; o_req_in = 1'b1;
    #1;
    check("lit rr2 o_ready", o_ready_out, 1);
    check("lit rr2 p_ready", p_ready_out, 0);
    step();
    check("lit rr2 p_ready next", p_ready_out, 1);
    step(); p_req_in = 1'b0; o_req_in = 1'b0;
    repeat (5) step();

    // Reset one cycle after an accept discards the lookup.
    p_req_in = 1'b1; step();
    p_req_in = 1'b0; rst_in = 1'b1; step();
    rst_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (p_valid_out) cnt++;
      step();
    end
    check("lit flight no p_valid", cnt, 0);
    p_req_in = 1'b1; step(); p_req_in = 1'b0;
    step(); step();
    check("lit flight relookup p_valid", p_valid_out, 1);
    step();

    // Active-video stall until hcount reaches the blanking boundary.
    vcount_in = 10'd50; p_req_in = 1'b1;
    cnt = 0;
    for (int h = 100; h < 1280; h++) begin
      hcount_in = 11'(h);
      #0;
      if (p_ready_out || map_sel_out) cnt++;
      step();
    end
    check("lit stall no ready", cnt, 0);
    hcount_in = 11'd1280;
    #1;
    check("lit stall accept at 1280", p_ready_out, 1);
    step(); p_req_in = 1'b0;
    repeat (4) step();

    // Vertical boundary, plus a request dropped before blanking.
    hcount_in = 11'd0; vcount_in = 10'd719; o_req_in = 1'b1; p_req_in = 1'b1;
    #1;
    check("lit v719 o_ready", o_ready_out, 0);
    step(); p_req_in = 1'b0;
    step(); vcount_in = 10'd720;
    #1;
    check("lit v720 o_ready", o_ready_out, 1);
    step(); o_req_in = 1'b0;
    repeat (4) step();

    // Continuous opponent request: accepts every 4 cycles.
    hcount_in = 11'd1300; vcount_in = 10'd100;
    o_x_in = 11'h7FF; o_y_in = 11'h000; o_req_in = 1'b1;
    cnt = 0; first_at = -1;
    for (int i = 0; i < 12; i++) begin
      #0;
      if (o_ready_out) begin
        cnt++;
        if (i % 4 != 0) first_at = i;
      end
      step();
    end
    o_req_in = 1'b0;
    check("lit block accepts", cnt, 3);
    check("lit block spacing", first_at, -1);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/track_query_arbiter.md
Name: track_query_arbiter

Overview:
- Shares the track-map and obstacle-map tile RAMs between the pixel renderer and two kart-physics requesters (player, opponent).
- The renderer owns the RAM address whenever the beam is in active video. During blanking, this block issues round-robin tile lookups and returns tile type and obstacle type to each requester.
- Sits beside the track renderer. It drives the arbiter side of the RAM address mux and samples the shared RAM output buses.

Parameters:
- H_ACTIVE, 1280, first blanking hcount value.
- V_ACTIVE, 720, first blanking vcount value.
- RAM_LATENCY, 2, cycles from address presented to valid RAM data (HIGH_PERFORMANCE BRAM).

Ports:
- clk_in  input  1  system/pixel clock
- rst_in  input  1  reset
- hcount_in  input  11  beam horizontal position
- vcount_in  input  10  beam vertical position
- p_req_in  input  1  player lookup request; coordinates held stable while high
- p_x_in  input  11  player x (quarter-pixel units; pixel = x[10:2])
- p_y_in  input  11  player y (quarter-pixel units)
- p_ready_out  output  1  player request accepted this cycle
- p_valid_out  output  1  player result valid (1-cycle pulse)
- p_tile_out  output  4  player tile type
- p_obstacle_out  output  4  player obstacle type
- o_req_in, o_x_in, o_y_in, o_ready_out, o_valid_out, o_tile_out, o_obstacle_out: same as the p_ ports, for the opponent.
- map_sel_out  output  1  1 = arbiter owns RAM address this cycle
- map_addr_out  output  8  arbiter RAM address {y[10:7], x[10:7]}
- track_data_in  input  4  shared track RAM douta
- obstacle_data_in  input  4  shared obstacle RAM douta

Behaviour:
- Clocking and reset:
  - One clock: clk_in. Reset rst_in is asynchronous, active-high.
  - Reset forces all registered outputs to 0 and clears the latency pipeline and both outstanding flags. The round-robin pointer resets to player.
  - In-flight lookups at reset are discarded; no valid pulse is ever produced for them.
- Blanking: blank = (hcount_in >= H_ACTIVE) || (vcount_in >= V_ACTIVE). No accept occurs when blank = 0.
- Eligibility: requester X is eligible when X_req_in = 1, X is not outstanding, and blank = 1.
- Grant (combinational):
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one named by the round-robin pointer is granted.
  - At most one grant per cycle.
  - X_ready_out = grant to X. Accept = req && ready in the same cycle.
- Issue on accept, in the same cycle (combinational):
  - map_sel_out = 1.
  - map_addr_out = {y[10:7], x[10:7]} of the granted requester.
  - Otherwise map_sel_out = 0 and map_addr_out = 0.
- Pointer and outstanding state on accept: the pointer flips to the other requester, and the granted requester's outstanding flag is set.
- Latency pipeline: a (RAM_LATENCY+1)-deep shift register of {valid, id}. If accept is in cycle t:
  - track_data_in and obstacle_data_in are sampled at the end of cycle t+RAM_LATENCY.
  - X_tile_out and X_obstacle_out take the sampled values, and X_valid_out = 1, during cycle t+RAM_LATENCY+1 only.
- Hold: tile/obstacle outputs hold their last value until the next result for that requester.
- Outstanding clear: the outstanding flag clears on the valid-pulse cycle. The earliest re-accept is the following cycle, so there is at most one outstanding lookup per requester.
- Interleaving: the pipeline carries up to one entry per cycle, so player and opponent lookups may interleave back to back.
- Blanking edge:
  - An accept on the last blanking cycle is legal. The RAM is pipelined, so its returning data does not collide with renderer reads.
  - Requests arriving during active video stall with ready = 0 until blank.
- Requester protocol: dropping X_req_in before accept is legal; no lookup occurs.

Test Plan:
- Reset: assert rst_in mid-frame -> all ready/valid/tile/obstacle/map outputs 0 immediately (async); pointer = player.
- Single lookup: hcount=1300, vcount=100, p_req=1, p_x=11'h1A0, p_y=11'h280 -> p_ready=1, map_sel=1, map_addr=8'h53 in the same cycle. RAM model returns track=2, obstacle=6 two cycles later -> p_valid pulse 3 cycles after accept with p_tile=2, p_obstacle=6, held afterward.
- Active-video stall: p_req held from hcount=100, vcount=50 -> p_ready=0 and map_sel=0 throughout. Accept occurs on the first cycle hcount=1280.
- Round-robin: both requests in blanking, pointer = player -> player accepted at t, opponent at t+1. Next simultaneous pair -> opponent first. Each result is routed to the correct requester.
- Reset mid-flight: rst_in pulsed one cycle after a p accept -> no p_valid ever. A subsequent request completes normally with latency 3.
- Outstanding block: o_req held continuously -> o_ready only at accept and again on the cycle after o_valid. Accepts repeat every 4 cycles in blanking.
